// File: rtl/gemm_result_collector_if.sv
// rtl/gemm_result_collector_if.sv - issue credit, array capture and result stream bundle for the GEMM result collector
interface gemm_result_collector_if #(
    parameter int SA_SIZE                = 8,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int DEPTH                  = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                              issue_valid;
    logic                              issue_ready;
    logic [WEIGHT_ACTIVATION_SIZE-1:0] sa_out [SA_SIZE];
    logic                              sa_output_valid;
    logic                              res_valid;
    logic                              res_ready;
    logic [WEIGHT_ACTIVATION_SIZE-1:0] res_data [SA_SIZE];
    logic                              res_last;
    logic [OCC_W-1:0]                  occupancy;
    logic                              err_protocol;
    logic                              err_latency;

    modport slave (
        input  issue_valid, sa_out, sa_output_valid, res_ready,
        output issue_ready, res_valid, res_data, res_last, occupancy, err_protocol, err_latency
    );

    modport master (
        output issue_valid, sa_out, sa_output_valid, res_ready,
        input  issue_ready, res_valid, res_data, res_last, occupancy, err_protocol, err_latency
    );
endinterface

// File: rtl/gemm_result_collector.sv
// rtl/gemm_result_collector.sv - tracks issues through the fixed-latency array and buffers results behind credits
module gemm_result_collector #(
    parameter int SA_SIZE                = 8,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int DEPTH                  = 4,
    parameter int ROWS                   = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    gemm_result_collector_if.slave bus
);
    localparam int LAT = 2 * SA_SIZE;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    typedef logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] vec_t;

    logic [LAT-1:0] trk;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  occ;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [RW-1:0]  row_cnt;
    vec_t           mem [DEPTH];
    vec_t           sa_vec;
    logic           accept;
    logic           cap;
    logic           pop;

    // Credits cover both buffered and in-flight vectors, so a capture always has a free slot.
    assign occ             = fifo_count + inflight;
    assign bus.occupancy   = occ;
    assign bus.issue_ready = occ < DEPTH_C;
    assign accept          = bus.issue_valid && bus.issue_ready;
    assign cap             = trk[LAT-1];
    assign bus.res_valid   = fifo_count != '0;
    assign pop             = bus.res_valid && bus.res_ready;
    assign bus.res_last    = bus.res_valid && (row_cnt == ROW_MAX);

    for (genvar i = 0; i < SA_SIZE; i++) begin : g_lane
        assign sa_vec[i]       = bus.sa_out[i];
        assign bus.res_data[i] = bus.res_valid ? mem[rd_ptr][i] : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trk              <= '0;
            inflight         <= '0;
            fifo_count       <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            row_cnt          <= '0;
            bus.err_protocol <= 1'b0;
            bus.err_latency  <= 1'b0;
        end else begin
            trk        <= {trk[LAT-2:0], accept};
            inflight   <= inflight + CW'(accept) - CW'(cap);
            fifo_count <= fifo_count + CW'(cap) - CW'(pop);
            if (cap) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
                row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
            end
            if (bus.issue_valid && !bus.issue_ready) begin
                bus.err_protocol <= 1'b1;
            end
            // A late array still gets its slot filled so later results stay in order.
            if (cap && !bus.sa_output_valid) begin
                bus.err_latency <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem[wr_ptr] <= sa_vec;
        end
    end
endmodule

// File: tb/tb_gemm_result_collector.sv
// tb/tb_gemm_result_collector.sv - scoreboard bench for gemm_result_collector
module tb_gemm_result_collector;
    localparam int SA_SIZE = 2;
    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int ROWS    = 2;
    localparam int LAT     = 2 * SA_SIZE;

    logic clk;
    logic resetn;

    gemm_result_collector_if #(.SA_SIZE(SA_SIZE), .WEIGHT_ACTIVATION_SIZE(W), .DEPTH(DEPTH)) bus ();

    gemm_result_collector #(
        .SA_SIZE(SA_SIZE), .WEIGHT_ACTIVATION_SIZE(W), .DEPTH(DEPTH), .ROWS(ROWS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pend_q [$];
    logic [15:0] fifo_q [$];
    logic [15:0] data_q [$];
    int          m_row  = 0;
    logic        m_errp = 1'b0;
    logic        m_errl = 1'b0;
    logic        cap_sov = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic rdy();
        return (fifo_q.size() + pend_q.size()) < DEPTH;
    endfunction

    task automatic cycle(input logic iv, input logic rr);
        logic [15:0] d;
        logic        cap;
        logic        acc;
        logic        ready;
        int          occ;
        occ   = fifo_q.size() + pend_q.size();
        ready = occ < DEPTH;
        chk("issue_ready", 64'(bus.issue_ready), 64'(ready));
        chk("occupancy", 64'(bus.occupancy), 64'(occ));
        chk("res_valid", 64'(bus.res_valid), 64'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            chk("res_data", 64'({bus.res_data[1], bus.res_data[0]}), 64'(fifo_q[0]));
        end
        chk("res_last", 64'(bus.res_last), 64'(fifo_q.size() != 0 && m_row == ROWS - 1));
        chk("err_protocol", 64'(bus.err_protocol), 64'(m_errp));
        chk("err_latency", 64'(bus.err_latency), 64'(m_errl));

        cap = pend_q.size() != 0 && pend_q[0] == cyc;
        d   = 16'($urandom);
        if (cap && data_q.size() != 0) d = data_q.pop_front();
        bus.sa_out[0]       = d[7:0];
        bus.sa_out[1]       = d[15:8];
        bus.sa_output_valid = cap ? cap_sov : 1'b0;
        bus.issue_valid     = iv;
        bus.res_ready       = rr;

        acc = iv && ready;
        if (iv && !ready) m_errp = 1'b1;
        if (rr && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end
        if (cap) begin
            void'(pend_q.pop_front());
            fifo_q.push_back(d);
            if (!cap_sov) m_errl = 1'b1;
        end
        if (acc) pend_q.push_back(cyc + LAT);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_issue_ready"}, 64'(bus.issue_ready), 64'd1);
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        chk({tag, "_res_data"}, 64'({bus.res_data[1], bus.res_data[0]}), 64'd0);
        chk({tag, "_res_last"}, 64'(bus.res_last), 64'd0);
        chk({tag, "_occupancy"}, 64'(bus.occupancy), 64'd0);
        chk({tag, "_err_protocol"}, 64'(bus.err_protocol), 64'd0);
        chk({tag, "_err_latency"}, 64'(bus.err_latency), 64'd0);
    endtask

    initial begin
        resetn              = 1'b0;
        bus.issue_valid     = 1'b0;
        bus.res_ready       = 1'b0;
        bus.sa_output_valid = 1'b0;
        bus.sa_out[0]       = '0;
        bus.sa_out[1]       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        resetn = 1'b1;

        // single issue, result after LAT+1 cycles, then popped
        data_q.push_back({8'd10, 8'd6});
        cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);
        chk("single_res_valid", 64'(bus.res_valid), 64'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // fill with ready honoured and no downstream acceptance
        data_q.push_back({8'd10, 8'd6});
        data_q.push_back({8'd4, 8'd9});
        repeat (10) cycle(rdy(), 1'b0);
        chk("fill_occupancy", 64'(bus.occupancy), 64'(DEPTH));
        chk("fill_no_proto_err", 64'(bus.err_protocol), 64'd0);

        // issue into a full collector: sticky protocol error, nothing tracked
        repeat (2) cycle(1'b1, 1'b0);
        repeat (LAT + 2) cycle(1'b0, 1'b0);

        // drain, watching res_last alternate and credits return
        repeat (6) cycle(1'b0, 1'b1);

        // late array output still captured in order
        cap_sov = 1'b0;
        cycle(1'b1, 1'b0);
        repeat (LAT + 1) cycle(1'b0, 1'b0);
        cap_sov = 1'b1;
        repeat (2) cycle(1'b0, 1'b1);

        // mixed random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (LAT + DEPTH + 2) cycle(1'b0, 1'b1);

        // reset while three issues are in flight
        repeat (3) cycle(1'b1, 1'b0);
        bus.issue_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        pend_q.delete();
        fifo_q.delete();
        data_q.delete();
        m_row  = 0;
        m_errp = 1'b0;
        m_errl = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        resetn = 1'b1;
        repeat (LAT + 4) cycle(1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            cycle(rdy() & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
